pong_frame_engine: RTL and testbench
====================================

# pong_frame_engine

Game-state and pixel-colour source for the 1280x800 @ 60 Hz display path, directly upstream of the VGA timing/sync driver. Once per frame it advances paddle and ball positions, resolves wall and paddle collisions, and keeps score. Every pixel clock it maps the driver's active-area pixel coordinate to a 4:4:4 RGB colour through a 2-stage pipeline.

## Interface
Parameters:
- H_ACTIVE, 1280, visible width in pixels
- V_ACTIVE, 800, visible height in lines
- PADDLE_W, 16, paddle width in pixels
- PADDLE_H, 128, paddle height in lines
- BALL_SIZE, 16, ball edge length in pixels
- PADDLE_L_X, 32, left paddle left edge
- PADDLE_R_X, 1232, right paddle left edge
- PADDLE_SPEED, 8, paddle step per frame
- BALL_SPEED, 4, ball step per frame, per axis
- SERVE_FRAMES, 60, frames held in SERVE
- WIN_SCORE, 9, score that ends the game

Ports:
- clk  in  1  pixel clock, 83.46 MHz, shared with the VGA driver
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame, issued during vertical blanking
- pixel_x  in  11  active-area column, 0..H_ACTIVE-1
- pixel_y  in  10  active-area row, 0..V_ACTIVE-1
- pixel_active  in  1  pixel_x/pixel_y are inside the visible area
- btn_l_up, btn_l_dn, btn_r_up, btn_r_dn  in  1 each  paddle controls, already synchronised and level-sensitive
- o_red, o_green, o_blue  out  4 each  pixel colour, 2 cycles after the matching pixel_x/pixel_y
- score_l, score_r  out  4 each  scores, 0..WIN_SCORE
- game_over  out  1  high in GAME_OVER

## Operation
- One clock: clk. Reset is synchronous and active-high.
- On reset:
  - State is SERVE and the serve counter is 0.
  - Ball is at (632, 392) with vx=+BALL_SPEED and vy=+BALL_SPEED.
  - Both paddles are at y=336.
  - Scores are 0, game_over=0, and all colour outputs and pipeline registers are 0.
- State only changes on a frame_tick cycle. Exception: reset overrides everything, including mid-frame and mid-PLAY.
- SERVE:
  - Ball is held at centre. Paddles move.
  - The serve counter increments on each frame_tick.
  - When the counter reaches SERVE_FRAMES-1 on a frame_tick, the state goes to PLAY and the counter clears.
- PLAY, on each frame_tick:
  - Paddles update first:
    - y -= PADDLE_SPEED if up only; y += PADDLE_SPEED if down only.
    - No move if both or neither button is pressed.
    - Result is clamped to 0..V_ACTIVE-PADDLE_H.
  - Ball next position = position + velocity, computed in 12-bit signed arithmetic.
  - Top/bottom walls:
    - next y <= 0: y=0 and vy is negated.
    - next y >= V_ACTIVE-BALL_SIZE: y=V_ACTIVE-BALL_SIZE and vy is negated.
  - Left paddle hit:
    - Conditions: vx<0, next x <= PADDLE_L_X+PADDLE_W, next x+BALL_SIZE > PADDLE_L_X, and the ball overlaps the paddle vertically (using the updated paddle y).
    - Response: x=PADDLE_L_X+PADDLE_W and vx=+BALL_SPEED.
  - Right paddle hit: mirror image, with x=PADDLE_R_X-BALL_SIZE and vx=-BALL_SPEED.
  - Miss: next x <= 0 → score_r+1; next x >= H_ACTIVE-BALL_SIZE → score_l+1. The state goes to SCORED.
  - Wall and paddle checks are independent. A corner hit negates both components.
- SCORED, on the next frame_tick:
  - If either score equals WIN_SCORE, go to GAME_OVER.
  - Otherwise go to SERVE with the ball recentred, vx pointing away from the scorer, and vy unchanged.
- GAME_OVER: positions and scores are frozen until reset.
- Render, priority high to low:
  - ball: FFF
  - left paddle: 0F0
  - right paddle: 00F
  - centre line: 444, for 638 <= x <= 641 and bit 4 of y = 0
  - background: 000 normally, 400 in GAME_OVER
- Hit tests use inclusive-left, exclusive-right bounds, e.g. x in [ball_x, ball_x+BALL_SIZE).
- When the delayed pixel_active is 0, the output is 000.

## Timing
- Render pipeline:
  - Stage 1 registers the hit flags and pixel_active.
  - Stage 2 registers the colour.
  - Latency is exactly 2 clk. Throughput is one pixel per clk with no stalls.
- Render reads the position/state registers directly. These registers change only on frame_tick, which falls in blanking, so there is no tearing.
- Scores and game_over are registered and update on the cycle after the frame_tick that causes the change.
- If frame_tick is asserted during an active pixel (protocol violation), the update still happens. Visual correctness is then not required.

## Test plan
- Reset, then 60 frame_ticks with no buttons → state PLAY after tick 60; after the next tick the ball is at (636, 396).
- Hold btn_l_up for 50 frames in SERVE → left paddle y=0 (clamped from 336); with both left buttons held for 10 frames → y unchanged.
- Force the ball to approach the top wall at y=2 with vy=-4 → after the tick y=0, vy=+4; for the same case at the bottom, y=784.
- Right paddle at y=300, ball reaching x=1216 within its rows with vx=+4 → x=1216, vx=-4, no score. With the paddle at y=0, the ball goes on to x >= 1264 → score_l=1, then SERVE with vx=-4.
- Drive nine left-side misses → score_r=9, game_over=1 one cycle after the SCORED tick. Further frame_ticks change nothing, the background renders 400, and reset returns all outputs to 0.
- Sweep pixel_x/pixel_y over the ball's rows with pixel_active → FFF appears exactly 2 cycles after the matching coordinate. With pixel_active=0 → 000.

Source files
------------

// File: rtl/pong_frame_engine.sv
// Pong game state advanced once per frame, plus a 2-stage pixel colour pipeline
// feeding the VGA timing/sync driver with 4:4:4 RGB.
module pong_frame_engine #(
    parameter int H_ACTIVE     = 1280,
    parameter int V_ACTIVE     = 800,
    parameter int PADDLE_W     = 16,
    parameter int PADDLE_H     = 128,
    parameter int BALL_SIZE    = 16,
    parameter int PADDLE_L_X   = 32,
    parameter int PADDLE_R_X   = 1232,
    parameter int PADDLE_SPEED = 8,
    parameter int BALL_SPEED   = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [10:0] pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        pixel_active,
    input  logic        btn_l_up,
    input  logic        btn_l_dn,
    input  logic        btn_r_up,
    input  logic        btn_r_dn,
    output logic [3:0]  o_red,
    output logic [3:0]  o_green,
    output logic [3:0]  o_blue,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        game_over
);

    typedef enum logic [1:0] {
        SERVE     = 2'd0,
        PLAY      = 2'd1,
        SCORED    = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    localparam logic signed [11:0] BALL_X0   = 12'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic signed [11:0] BALL_Y0   = 12'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic signed [11:0] PAD_Y0    = 12'((V_ACTIVE - PADDLE_H) / 2);
    localparam logic signed [11:0] PAD_Y_MAX = 12'(V_ACTIVE - PADDLE_H);
    localparam logic signed [11:0] X_MAX     = 12'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [11:0] Y_MAX     = 12'(V_ACTIVE - BALL_SIZE);
    localparam logic signed [11:0] L_EDGE    = 12'(PADDLE_L_X + PADDLE_W);
    localparam logic signed [11:0] R_EDGE    = 12'(PADDLE_R_X - BALL_SIZE);
    localparam logic signed [11:0] PLX       = 12'(PADDLE_L_X);
    localparam logic signed [11:0] PRX       = 12'(PADDLE_R_X);
    localparam logic signed [11:0] PW        = 12'(PADDLE_W);
    localparam logic signed [11:0] PH        = 12'(PADDLE_H);
    localparam logic signed [11:0] BS        = 12'(BALL_SIZE);
    localparam logic signed [11:0] SPD       = 12'(BALL_SPEED);
    localparam logic signed [11:0] P_SPD     = 12'(PADDLE_SPEED);
    localparam logic signed [11:0] CL_X0     = 12'(H_ACTIVE / 2 - 2);
    localparam logic signed [11:0] CL_X1     = 12'(H_ACTIVE / 2 + 1);
    localparam logic [7:0]         SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [3:0]         WIN        = 4'(WIN_SCORE);

    state_t             state, state_next;
    logic [7:0]         serve_cnt, serve_cnt_next;
    logic signed [11:0] ball_x, ball_x_next;
    logic signed [11:0] ball_y, ball_y_next;
    logic signed [11:0] ball_vx, ball_vx_next;
    logic signed [11:0] ball_vy, ball_vy_next;
    logic signed [11:0] pad_l_y, pad_l_y_next;
    logic signed [11:0] pad_r_y, pad_r_y_next;
    logic [3:0]         score_l_next, score_r_next;
    logic               point_l, point_l_next;

    logic signed [11:0] pad_l_step, pad_r_step;
    logic signed [11:0] nx, ny, ny_wall, vy_wall, nx_res;
    logic               v_l, v_r, hit_l, hit_r;

    function automatic logic signed [11:0] step_paddle(input logic signed [11:0] y,
                                                       input logic up,
                                                       input logic dn);
        logic signed [11:0] t;
        t = y;
        if (up && !dn)
            t = y - P_SPD;
        else if (dn && !up)
            t = y + P_SPD;
        if (t < 12'sd0)
            t = 12'sd0;
        else if (t > PAD_Y_MAX)
            t = PAD_Y_MAX;
        return t;
    endfunction

    assign pad_l_step = step_paddle(pad_l_y, btn_l_up, btn_l_dn);
    assign pad_r_step = step_paddle(pad_r_y, btn_r_up, btn_r_dn);

    // Candidate ball move and wall bounce; paddle overlap uses the freshly stepped paddles.
    assign nx = ball_x + ball_vx;
    assign ny = ball_y + ball_vy;

    always_comb begin
        ny_wall = ny;
        vy_wall = ball_vy;
        if (ny <= 12'sd0) begin
            ny_wall = 12'sd0;
            vy_wall = -ball_vy;
        end else if (ny >= Y_MAX) begin
            ny_wall = Y_MAX;
            vy_wall = -ball_vy;
        end
    end

    assign v_l   = (ny_wall < pad_l_step + PH) && (ny_wall + BS > pad_l_step);
    assign v_r   = (ny_wall < pad_r_step + PH) && (ny_wall + BS > pad_r_step);
    assign hit_l = (ball_vx < 12'sd0) && (nx <= L_EDGE) && (nx + BS > PLX) && v_l;
    assign hit_r = (ball_vx > 12'sd0) && (nx + BS >= PRX) && (nx < PRX + PW) && v_r;

    // Next-state logic: everything holds unless this is a frame_tick cycle.
    always_comb begin
        state_next     = state;
        serve_cnt_next = serve_cnt;
        ball_x_next    = ball_x;
        ball_y_next    = ball_y;
        ball_vx_next   = ball_vx;
        ball_vy_next   = ball_vy;
        pad_l_y_next   = pad_l_y;
        pad_r_y_next   = pad_r_y;
        score_l_next   = score_l;
        score_r_next   = score_r;
        point_l_next   = point_l;
        nx_res         = nx;
        if (frame_tick) begin
            case (state)
                SERVE: begin
                    pad_l_y_next = pad_l_step;
                    pad_r_y_next = pad_r_step;
                    if (serve_cnt == SERVE_LAST) begin
                        state_next     = PLAY;
                        serve_cnt_next = 8'd0;
                    end else begin
                        serve_cnt_next = serve_cnt + 8'd1;
                    end
                end
                PLAY: begin
                    pad_l_y_next = pad_l_step;
                    pad_r_y_next = pad_r_step;
                    ball_y_next  = ny_wall;
                    ball_vy_next = vy_wall;
                    if (hit_l) begin
                        nx_res       = L_EDGE;
                        ball_vx_next = SPD;
                    end else if (hit_r) begin
                        nx_res       = R_EDGE;
                        ball_vx_next = -SPD;
                    end else if (nx <= 12'sd0) begin
                        nx_res       = 12'sd0;
                        score_r_next = score_r + 4'd1;
                        point_l_next = 1'b0;
                        state_next   = SCORED;
                    end else if (nx >= X_MAX) begin
                        nx_res       = X_MAX;
                        score_l_next = score_l + 4'd1;
                        point_l_next = 1'b1;
                        state_next   = SCORED;
                    end
                    ball_x_next = nx_res;
                end
                SCORED: begin
                    pad_l_y_next = pad_l_step;
                    pad_r_y_next = pad_r_step;
                    if (score_l == WIN || score_r == WIN) begin
                        state_next = GAME_OVER;
                    end else begin
                        state_next   = SERVE;
                        ball_x_next  = BALL_X0;
                        ball_y_next  = BALL_Y0;
                        ball_vx_next = point_l ? -SPD : SPD;
                    end
                end
                GAME_OVER: begin
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SERVE;
            serve_cnt <= 8'd0;
            ball_x    <= BALL_X0;
            ball_y    <= BALL_Y0;
            ball_vx   <= SPD;
            ball_vy   <= SPD;
            pad_l_y   <= PAD_Y0;
            pad_r_y   <= PAD_Y0;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            point_l   <= 1'b0;
        end else begin
            state     <= state_next;
            serve_cnt <= serve_cnt_next;
            ball_x    <= ball_x_next;
            ball_y    <= ball_y_next;
            ball_vx   <= ball_vx_next;
            ball_vy   <= ball_vy_next;
            pad_l_y   <= pad_l_y_next;
            pad_r_y   <= pad_r_y_next;
            score_l   <= score_l_next;
            score_r   <= score_r_next;
            point_l   <= point_l_next;
        end
    end

    assign game_over = (state == GAME_OVER);

    // Render: inclusive-left, exclusive-right hit tests against the frame-stable registers.
    logic signed [11:0] px, py;
    logic               hit_ball, hit_pl, hit_pr, hit_cl;
    logic               s1_ball, s1_pl, s1_pr, s1_cl, s1_active, s1_over;
    logic [11:0]        rgb_next;

    assign px       = $signed({1'b0, pixel_x});
    assign py       = $signed({2'b00, pixel_y});
    assign hit_ball = (px >= ball_x) && (px < ball_x + BS) && (py >= ball_y) && (py < ball_y + BS);
    assign hit_pl   = (px >= PLX) && (px < PLX + PW) && (py >= pad_l_y) && (py < pad_l_y + PH);
    assign hit_pr   = (px >= PRX) && (px < PRX + PW) && (py >= pad_r_y) && (py < pad_r_y + PH);
    assign hit_cl   = (px >= CL_X0) && (px <= CL_X1) && !pixel_y[4];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_ball   <= 1'b0;
            s1_pl     <= 1'b0;
            s1_pr     <= 1'b0;
            s1_cl     <= 1'b0;
            s1_active <= 1'b0;
            s1_over   <= 1'b0;
        end else begin
            s1_ball   <= hit_ball;
            s1_pl     <= hit_pl;
            s1_pr     <= hit_pr;
            s1_cl     <= hit_cl;
            s1_active <= pixel_active;
            s1_over   <= (state == GAME_OVER);
        end
    end

    always_comb begin
        rgb_next = 12'h000;
        if (s1_active) begin
            if (s1_ball)
                rgb_next = 12'hFFF;
            else if (s1_pl)
                rgb_next = 12'h0F0;
            else if (s1_pr)
                rgb_next = 12'h00F;
            else if (s1_cl)
                rgb_next = 12'h444;
            else if (s1_over)
                rgb_next = 12'h400;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_red   <= 4'h0;
            o_green <= 4'h0;
            o_blue  <= 4'h0;
        end else begin
            o_red   <= rgb_next[11:8];
            o_green <= rgb_next[7:4];
            o_blue  <= rgb_next[3:0];
        end
    end

endmodule

// File: tb/tb_pong_frame_engine.sv
// Directed bench for pong_frame_engine: serve timing, paddle clamping, wall and
// paddle bounces, scoring, game over and the 2-cycle render pipeline.
module tb_pong_frame_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic [10:0] pixel_x = 11'd0;
    logic [9:0]  pixel_y = 10'd0;
    logic        pixel_active = 1'b0;
    logic        btn_l_up = 1'b0, btn_l_dn = 1'b0, btn_r_up = 1'b0, btn_r_dn = 1'b0;
    logic [3:0]  o_red, o_green, o_blue, score_l, score_r;
    logic        game_over;
    logic [1:0]  st;

    int checks = 0;
    int errors = 0;

    pong_frame_engine dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_active(pixel_active),
        .btn_l_up(btn_l_up), .btn_l_dn(btn_l_dn), .btn_r_up(btn_r_up), .btn_r_dn(btn_r_dn),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .score_l(score_l), .score_r(score_r), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_point(input string tag, input int x, input int y, input logic act,
                               input logic [11:0] exp);
        @(negedge clk);
        pixel_x = 11'(x);
        pixel_y = 10'(y);
        pixel_active = act;
        @(negedge clk);
        @(negedge clk);
        check_output(tag, {20'd0, o_red, o_green, o_blue}, {20'd0, exp});
        pixel_active = 1'b0;
    endtask

    // Streams one pixel per clock and checks each colour exactly two clocks later.
    task automatic check_sweep(input int x0, input int y, input int n, input int lo, input int hi,
                               input logic [11:0] c_lo, input logic [11:0] c_in, input logic [11:0] c_hi);
        int xs;
        logic [11:0] exp;
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                xs = x0 + i - 2;
                exp = (xs < lo) ? c_lo : ((xs <= hi) ? c_in : c_hi);
                check_output($sformatf("sweep_x%0d", xs), {20'd0, o_red, o_green, o_blue}, {20'd0, exp});
            end
            if (i < n) begin
                pixel_x = 11'(x0 + i);
                pixel_y = 10'(y);
                pixel_active = 1'b1;
            end else begin
                pixel_active = 1'b0;
            end
        end
    endtask

    initial begin
        // Reset state
        apply_reset();
        st = dut.state;
        check_output("rst_rgb", {20'd0, o_red, o_green, o_blue}, 32'h000);
        check_output("rst_score_l", score_l, 0);
        check_output("rst_score_r", score_r, 0);
        check_output("rst_game_over", game_over, 0);
        check_output("rst_state", st, 0);
        check_output("rst_ball_x", dut.ball_x, 632);
        check_output("rst_ball_y", dut.ball_y, 392);
        check_output("rst_pad_l", dut.pad_l_y, 336);
        check_output("rst_pad_r", dut.pad_r_y, 336);
        check_output("rst_vx", $unsigned(dut.ball_vx), 32'h004);
        check_output("rst_vy", $unsigned(dut.ball_vy), 32'h004);
        reset = 1'b0;

        // Serve lasts 60 ticks
        apply_stimulus(59);
        st = dut.state;
        check_output("serve_59_state", st, 0);
        check_output("serve_59_ball_x", dut.ball_x, 632);
        apply_stimulus(1);
        st = dut.state;
        check_output("serve_60_state", st, 1);
        check_output("serve_60_ball_x", dut.ball_x, 632);
        apply_stimulus(1);
        check_output("play1_ball_x", dut.ball_x, 636);
        check_output("play1_ball_y", dut.ball_y, 396);

        // Bottom wall on play tick 98
        apply_stimulus(97);
        check_output("bottom_ball_y", dut.ball_y, 784);
        check_output("bottom_vy", $unsigned(dut.ball_vy), 32'hFFC);
        check_output("bottom_ball_x", dut.ball_x, 1024);

        // Right paddle at 336 misses; right edge reached on play tick 158
        apply_stimulus(59);
        check_output("pre_miss_ball_x", dut.ball_x, 1260);
        check_output("pre_miss_score_l", score_l, 0);
        apply_stimulus(1);
        st = dut.state;
        check_output("miss_r_score_l", score_l, 1);
        check_output("miss_r_state", st, 2);
        check_output("miss_r_ball_x", dut.ball_x, 1264);
        apply_stimulus(1);
        st = dut.state;
        check_output("reserve_state", st, 0);
        check_output("reserve_ball_x", dut.ball_x, 632);
        check_output("reserve_vx", $unsigned(dut.ball_vx), 32'hFFC);
        check_output("reserve_vy", $unsigned(dut.ball_vy), 32'hFFC);

        // Reset mid-serve clears the score
        apply_reset();
        check_output("rst2_score_l", score_l, 0);
        check_output("rst2_vx", $unsigned(dut.ball_vx), 32'h004);
        reset = 1'b0;

        // Paddle moves and clamping during serve
        btn_l_up = 1'b1;
        btn_r_dn = 1'b1;
        apply_stimulus(25);
        check_output("pad_l_25", dut.pad_l_y, 136);
        check_output("pad_r_25", dut.pad_r_y, 536);
        btn_r_dn = 1'b0;
        apply_stimulus(25);
        check_output("pad_l_clamp", dut.pad_l_y, 0);
        check_output("pad_r_hold", dut.pad_r_y, 536);
        btn_l_dn = 1'b1;
        apply_stimulus(10);
        st = dut.state;
        check_output("pad_l_both", dut.pad_l_y, 0);
        check_output("serve2_state", st, 1);
        btn_l_up = 1'b0;
        btn_l_dn = 1'b0;

        // Bottom wall, then right paddle hit at x=1216
        apply_stimulus(98);
        check_output("r2_bottom_y", dut.ball_y, 784);
        apply_stimulus(48);
        st = dut.state;
        check_output("rhit_ball_x", dut.ball_x, 1216);
        check_output("rhit_ball_y", dut.ball_y, 592);
        check_output("rhit_vx", $unsigned(dut.ball_vx), 32'hFFC);
        check_output("rhit_score_l", score_l, 0);
        check_output("rhit_state", st, 1);

        // Render with ball at (1216,592), left paddle y=0, right paddle y=536
        check_sweep(1212, 600, 24, 1216, 1231, 12'h000, 12'hFFF, 12'h00F);
        check_point("lpad_tl", 32, 0, 1'b1, 12'h0F0);
        check_point("lpad_br", 47, 127, 1'b1, 12'h0F0);
        check_point("lpad_right_out", 48, 0, 1'b1, 12'h000);
        check_point("lpad_below_out", 32, 128, 1'b1, 12'h000);
        check_point("rpad_br", 1247, 663, 1'b1, 12'h00F);
        check_point("rpad_above_out", 1240, 535, 1'b1, 12'h000);
        check_point("rpad_below_out", 1240, 664, 1'b1, 12'h000);
        check_point("cl_left", 638, 0, 1'b1, 12'h444);
        check_point("cl_right", 641, 15, 1'b1, 12'h444);
        check_point("cl_x642", 642, 15, 1'b1, 12'h000);
        check_point("cl_x637", 637, 0, 1'b1, 12'h000);
        check_point("cl_gap", 640, 16, 1'b1, 12'h000);
        check_point("cl_dash2", 640, 32, 1'b1, 12'h444);
        check_point("inactive_ball", 1220, 600, 1'b0, 12'h000);

        // Top wall
        apply_stimulus(148);
        check_output("top_ball_y", dut.ball_y, 0);
        check_output("top_vy", $unsigned(dut.ball_vy), 32'h004);
        check_output("top_ball_x", dut.ball_x, 624);

        // Left paddle at y=0 misses the ball at rows 576+
        apply_stimulus(155);
        check_output("pre_lmiss_x", dut.ball_x, 4);
        check_output("pre_lmiss_y", dut.ball_y, 620);
        check_output("pre_lmiss_score_r", score_r, 0);
        apply_stimulus(1);
        st = dut.state;
        check_output("lmiss_score_r", score_r, 1);
        check_output("lmiss_ball_x", dut.ball_x, 0);
        check_output("lmiss_state", st, 2);
        apply_stimulus(1);
        check_output("lserve_ball_x", dut.ball_x, 632);
        check_output("lserve_vx", $unsigned(dut.ball_vx), 32'h004);
        check_output("lserve_vy", $unsigned(dut.ball_vy), 32'h004);

        // Eight more identical rallies, each ending in a left miss
        for (int r = 2; r <= 9; r++) begin
            apply_stimulus(510);
            check_output($sformatf("rally%0d_score_r", r), score_r, r);
            check_output($sformatf("rally%0d_score_l", r), score_l, 0);
            if (r < 9) apply_stimulus(1);
        end

        // game_over rises the cycle after the SCORED tick
        check_output("go_before", game_over, 0);
        @(negedge clk) frame_tick = 1'b1;
        #1;
        check_output("go_during_tick", game_over, 0);
        @(negedge clk) frame_tick = 1'b0;
        st = dut.state;
        check_output("go_after", game_over, 1);
        check_output("go_state", st, 3);

        // Frozen in GAME_OVER
        apply_stimulus(5);
        check_output("frozen_score_r", score_r, 9);
        check_output("frozen_score_l", score_l, 0);
        check_output("frozen_ball_x", dut.ball_x, 0);
        check_output("frozen_go", game_over, 1);
        check_point("go_background", 100, 100, 1'b1, 12'h400);

        // Reset out of GAME_OVER
        apply_reset();
        st = dut.state;
        check_output("rst3_rgb", {20'd0, o_red, o_green, o_blue}, 32'h000);
        check_output("rst3_score_r", score_r, 0);
        check_output("rst3_game_over", game_over, 0);
        check_output("rst3_state", st, 0);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
